// File: rtl/pwm_period_meter_if.sv
// rtl/pwm_period_meter_if.sv - sample handshake bundle between the PWM period meter and its consumer
interface pwm_period_meter_if #(
    parameter int WIDTH = 18
);
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             sample_valid;
    logic             sample_ack;
    logic             overrun;

    modport master (
        output period,
        output high_time,
        output sample_valid,
        output overrun,
        input  sample_ack
    );

    modport slave (
        input  period,
        input  high_time,
        input  sample_valid,
        input  overrun,
        output sample_ack
    );
endinterface

// File: rtl/pwm_period_meter.sv
// rtl/pwm_period_meter.sv - measures PWM period and high time; PWM_METER_AVG_EN reports a 4-period average
module pwm_period_meter #(
    parameter int WIDTH      = 18,
    parameter int MIN_PERIOD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pwm_in,
    output logic                 silent,
    pwm_period_meter_if.master   smp
);
    typedef enum logic {S_SILENT = 1'b0, S_MEASURE = 1'b1} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] MIN_CNT = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state_q, state_d;
    logic             s1_q, sync_q, prev_q;
    logic [WIDTH-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic             fall_seen_q, fall_seen_d;
    logic [WIDTH-1:0] period_q, period_d, high_q, high_d;
    logic             valid_q, valid_d, ovr_q, ovr_d;
    logic             rise, fall, meas, load;
    logic [WIDTH-1:0] new_p, new_h;

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_SILENT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SILENT:  if (rise) state_d = S_MEASURE;
            S_MEASURE: if (!rise && cnt_q == CNT_MAX) state_d = S_SILENT;
            default:   state_d = S_SILENT;
        endcase
    end

    // Counters saturate at CNT_MAX; the state machine then drops to SILENT.
    always_comb begin
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        fall_seen_d = fall_seen_q;
        meas        = 1'b0;
        case (state_q)
            S_SILENT: begin
                if (rise) begin
                    cnt_d       = ONE;
                    hcnt_d      = ONE;
                    fall_seen_d = 1'b0;
                end
            end
            S_MEASURE: begin
                if (rise && cnt_q >= MIN_CNT) begin
                    meas        = 1'b1;
                    cnt_d       = ONE;
                    hcnt_d      = ONE;
                    fall_seen_d = 1'b0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + ONE;
                    if (sync_q && !fall_seen_q) hcnt_d = hcnt_q + ONE;
                    if (fall) fall_seen_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef PWM_METER_AVG_EN
    logic [3:0][WIDTH-1:0] p_hist_q, p_hist_d, h_hist_q, h_hist_d;
    logic [2:0]            fill_q, fill_d;
    logic [WIDTH+1:0]      p_sum_q, p_sum_d, h_sum_q, h_sum_d;

    // Running sums: add the newest period, drop the one leaving the 4-deep window.
    always_comb begin
        p_hist_d = p_hist_q;
        h_hist_d = h_hist_q;
        fill_d   = fill_q;
        p_sum_d  = p_sum_q;
        h_sum_d  = h_sum_q;
        load     = 1'b0;
        if (state_q == S_SILENT) begin
            p_hist_d = '0;
            h_hist_d = '0;
            fill_d   = 3'd0;
            p_sum_d  = '0;
            h_sum_d  = '0;
        end else if (meas) begin
            p_sum_d  = p_sum_q + {2'b00, cnt_q} - {2'b00, p_hist_q[3]};
            h_sum_d  = h_sum_q + {2'b00, hcnt_q} - {2'b00, h_hist_q[3]};
            p_hist_d = {p_hist_q[2:0], cnt_q};
            h_hist_d = {h_hist_q[2:0], hcnt_q};
            if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
            load = (fill_q >= 3'd3);
        end
        new_p = p_sum_d[WIDTH+1:2];
        new_h = h_sum_d[WIDTH+1:2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_hist_q <= '0;
            h_hist_q <= '0;
            fill_q   <= 3'd0;
            p_sum_q  <= '0;
            h_sum_q  <= '0;
        end else begin
            p_hist_q <= p_hist_d;
            h_hist_q <= h_hist_d;
            fill_q   <= fill_d;
            p_sum_q  <= p_sum_d;
            h_sum_q  <= h_sum_d;
        end
    end
`else
    assign load  = meas;
    assign new_p = cnt_q;
    assign new_h = hcnt_q;
`endif

    always_comb begin
        period_d = period_q;
        high_d   = high_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        if (load) begin
            period_d = new_p;
            high_d   = new_h;
            valid_d  = 1'b1;
            if (valid_q && !smp.sample_ack) ovr_d = 1'b1;
        end else if (smp.sample_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= 1'b0;
            sync_q      <= 1'b0;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            fall_seen_q <= 1'b0;
            period_q    <= '0;
            high_q      <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            s1_q        <= pwm_in;
            sync_q      <= s1_q;
            prev_q      <= sync_q;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            fall_seen_q <= fall_seen_d;
            period_q    <= period_d;
            high_q      <= high_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign silent           = (state_q == S_SILENT);
    assign smp.period       = period_q;
    assign smp.high_time    = high_q;
    assign smp.sample_valid = valid_q;
    assign smp.overrun      = ovr_q;
endmodule

// File: tb/tb_pwm_period_meter.sv
// tb/tb_pwm_period_meter.sv - randomized self-checking bench for pwm_period_meter
module tb_pwm_period_meter;
    localparam int W    = 8;
    localparam int MINP = 4;

    logic clk = 1'b0;
    logic rst;
    logic pwm_in;
    logic silent;

    pwm_period_meter_if #(.WIDTH(W)) bus ();

    pwm_period_meter #(.WIDTH(W), .MIN_PERIOD(MINP)) dut (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .silent (silent),
        .smp    (bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: expected outputs plus the waveform history it needs.
    int m_period, m_high;
    bit m_valid, m_ovr, m_silent, m_armed;
    int last_p, last_h;
    int hp[$];
    int hh[$];

    task automatic model_reset();
        m_period = 0; m_high = 0; m_valid = 0; m_ovr = 0;
        m_silent = 1; m_armed = 0; last_p = 0; last_h = 0;
        hp.delete(); hh.delete();
    endtask

    task automatic model_silence();
        m_armed = 0; m_silent = 1;
        hp.delete(); hh.delete();
    endtask

    // Effect of the rise that opens a new waveform period (3rd edge after the pin rise).
    task automatic model_rise(input bit ack_now);
        bit ld;
        int np, nh;
        ld = 0; np = 0; nh = 0;
        if (m_armed) begin
`ifdef PWM_METER_AVG_EN
            hp.push_back(last_p);
            hh.push_back(last_h);
            if (hp.size() > 4) begin hp.delete(0); hh.delete(0); end
            if (hp.size() == 4) begin
                ld = 1;
                np = (hp[0] + hp[1] + hp[2] + hp[3]) / 4;
                nh = (hh[0] + hh[1] + hh[2] + hh[3]) / 4;
            end
`else
            ld = 1; np = last_p; nh = last_h;
`endif
        end
        m_armed = 1; m_silent = 0;
        if (ld) begin
            if (m_valid && !ack_now) m_ovr = 1;
            m_valid = 1; m_period = np; m_high = nh;
        end else if (ack_now) begin
            m_valid = 0; m_ovr = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pwm_in = 1'b0; bus.sample_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // One PWM period of p cycles, high for h; glitch inserts a 1-low notch after the first high cycle.
    // ackm: 0 none, 1 ack after the sample, 2 ack coincident with the sample, 3 ack mid-period.
    task automatic run_period(input int p, input int h, input bit glitch, input int ackm, input string tag);
        int hexp;
        bit chk;
        hexp = glitch ? 1 : h;
        for (int i = 0; i < p; i++) begin
            @(negedge clk);
            chk = 0;
            if (i == 2) chk = 1;
            if (i == 3) begin model_rise(ackm == 2); chk = 1; end
            if ((ackm == 1 && i == 4) || (ackm == 3 && i == p / 2 + 1)) begin
                m_valid = 0; m_ovr = 0; chk = 1;
            end
            if (chk) begin
                total++;
                if ({bus.sample_valid, bus.overrun, silent, bus.period, bus.high_time} !==
                    {m_valid, m_ovr, m_silent, W'(m_period), W'(m_high)}) begin
                    bad++;
                    $display("FAIL %s i=%0d got v=%0b o=%0b s=%0b p=%0d h=%0d want v=%0b o=%0b s=%0b p=%0d h=%0d",
                             tag, i, bus.sample_valid, bus.overrun, silent, bus.period, bus.high_time,
                             m_valid, m_ovr, m_silent, m_period, m_high);
                end
            end
            pwm_in = glitch ? (i == 0 || (i >= 2 && i < h)) : (i < h);
            bus.sample_ack = (ackm == 1 && i == 3) || (ackm == 2 && i == 2) || (ackm == 3 && i == p / 2);
        end
        last_p = p; last_h = hexp;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.sample_valid, bus.overrun, silent, bus.period, bus.high_time} !== {1'b0, 1'b0, 1'b1, W'(0), W'(0)}) begin
            bad++;
            $display("FAIL reset got v=%0b o=%0b s=%0b p=%0d h=%0d want 0 0 1 0 0",
                     bus.sample_valid, bus.overrun, silent, bus.period, bus.high_time);
        end
    endtask

    task automatic test_square();
        do_reset();
        for (int k = 0; k < 4; k++) run_period(200, 100, 0, 1, "square");
    endtask

    task automatic test_duty_ack();
        do_reset();
        for (int k = 0; k < 4; k++) run_period(200, 30, 0, 1, "duty30");
    endtask

    task automatic test_overrun();
        do_reset();
        for (int k = 0; k < 3; k++) run_period(200, 30, 0, 0, "overrun");
`ifndef PWM_METER_AVG_EN
        total++;
        if (bus.overrun !== 1'b1 || bus.period !== W'(200) || bus.high_time !== W'(30)) begin
            bad++;
            $display("FAIL overrun_flag got o=%0b p=%0d h=%0d want o=1 p=200 h=30",
                     bus.overrun, bus.period, bus.high_time);
        end
`endif
        run_period(200, 30, 0, 3, "overrun_clear");
        run_period(150, 60, 0, 2, "coincident_ack");
        run_period(120, 20, 0, 0, "after_coincident");
        run_period(120, 20, 0, 1, "final_ack");
    endtask

    task automatic test_glitch();
        do_reset();
        for (int k = 0; k < 4; k++) run_period(200, 100, 1, 1, "glitch");
    endtask

    task automatic test_silence();
        do_reset();
        run_period(100, 50, 0, 1, "pre_silence");
        run_period(100, 50, 0, 0, "pre_silence");
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 3) model_rise(1'b0);
            if (i == 258) model_silence();
            if (i == 257 || i == 258 || i == 299) begin
                total++;
                if ({bus.sample_valid, silent, bus.period, bus.high_time} !==
                    {m_valid, m_silent, W'(m_period), W'(m_high)}) begin
                    bad++;
                    $display("FAIL silence i=%0d got v=%0b s=%0b p=%0d h=%0d want v=%0b s=%0b p=%0d h=%0d",
                             i, bus.sample_valid, silent, bus.period, bus.high_time,
                             m_valid, m_silent, m_period, m_high);
                end
            end
            pwm_in = (i < 100);
        end
        run_period(100, 40, 0, 1, "wake");
        run_period(100, 40, 0, 1, "wake");
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_period(80, 40, 0, 1, "pre_rst");
        run_period(80, 40, 0, 1, "pre_rst");
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            pwm_in = (i < 10);
        end
        do_reset();
        total++;
        if ({bus.sample_valid, silent, bus.period} !== {1'b0, 1'b1, W'(0)}) begin
            bad++;
            $display("FAIL mid_reset got v=%0b s=%0b p=%0d want v=0 s=1 p=0", bus.sample_valid, silent, bus.period);
        end
        run_period(90, 10, 0, 1, "post_rst");
        run_period(90, 10, 0, 1, "post_rst");
    endtask

    task automatic test_random();
        int p, h, am;
        bit g;
        do_reset();
        for (int k = 0; k < 24; k++) begin
            p  = $urandom_range(250, 6);
            h  = $urandom_range(p - 1, 1);
            g  = (h >= 3) && ($urandom_range(3, 0) == 0);
            am = $urandom_range(3, 0);
            run_period(p, h, g, am, "random");
        end
    endtask

`ifdef PWM_METER_AVG_EN
    task automatic test_avg();
        do_reset();
        run_period(200, 100, 0, 0, "avg");
        run_period(204, 102, 0, 0, "avg");
        run_period(200, 100, 0, 0, "avg");
        run_period(204, 102, 0, 0, "avg");
        run_period(200, 100, 0, 0, "avg");
        total++;
        if (bus.sample_valid !== 1'b1 || bus.period !== W'(202) || bus.high_time !== W'(101)) begin
            bad++;
            $display("FAIL avg4 got v=%0b p=%0d h=%0d want v=1 p=202 h=101",
                     bus.sample_valid, bus.period, bus.high_time);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_square();
        test_duty_ack();
        test_overrun();
        test_glitch();
        test_silence();
        test_reset_mid();
        test_random();
`ifdef PWM_METER_AVG_EN
        test_avg();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
